// File: rtl/ws2812_bit_enc.sv
// WS2812 single-bit NRZ line encoder: one bit per bit_rdy_in, one bit_done_out pulse per bit period.
// Optional one-entry skid buffer for requests arriving mid-bit: define WS2812_BIT_ENC_SKID_EN.
module ws2812_bit_enc #(
    parameter int unsigned T0H_CNT  = 80,
    parameter int unsigned T1H_CNT  = 160,
    parameter int unsigned TBIT_CNT = 250
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic bit_rdy_in,
    input  logic bit_data_in,
    output logic bit_done_out,
    output logic dout_out,
    output logic busy_out,
    output logic overrun_out
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CNT);
    localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TBIT_CNT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             dout_d, busy_d, done_d, ovr_d;
`ifdef WS2812_BIT_ENC_SKID_EN
    logic             skid_vld_q, skid_vld_d;
    logic             skid_bit_q, skid_bit_d;
`endif

    // Next-state logic; outputs are registered images of the current bit cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        ovr_d      = 1'b0;
`ifdef WS2812_BIT_ENC_SKID_EN
        skid_vld_d = skid_vld_q;
        skid_bit_d = skid_bit_q;
`endif
        busy_d = (state_q == ST_SEND);
        dout_d = busy_d && (cnt_q < (bit_q ? T1H : T0H));
        done_d = busy_d && (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                if (bit_rdy_in) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                    bit_d   = bit_data_in;
                end
            end
            ST_SEND: begin
                if (cnt_q == CNT_LAST) begin
                    // Final cycle: chain the next bit with zero gap if one is available
`ifdef WS2812_BIT_ENC_SKID_EN
                    if (skid_vld_q) begin
                        cnt_d      = '0;
                        bit_d      = skid_bit_q;
                        skid_vld_d = bit_rdy_in;
                        skid_bit_d = bit_data_in;
                    end else
`endif
                    if (bit_rdy_in) begin
                        cnt_d = '0;
                        bit_d = bit_data_in;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bit_rdy_in) begin
`ifdef WS2812_BIT_ENC_SKID_EN
                        if (!skid_vld_q) begin
                            skid_vld_d = 1'b1;
                            skid_bit_d = bit_data_in;
                        end else begin
                            ovr_d = 1'b1;
                        end
`else
                        ovr_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= 1'b0;
            dout_out     <= 1'b0;
            busy_out     <= 1'b0;
            bit_done_out <= 1'b0;
            overrun_out  <= 1'b0;
`ifdef WS2812_BIT_ENC_SKID_EN
            skid_vld_q   <= 1'b0;
            skid_bit_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            dout_out     <= dout_d;
            busy_out     <= busy_d;
            bit_done_out <= done_d;
            overrun_out  <= ovr_d;
`ifdef WS2812_BIT_ENC_SKID_EN
            skid_vld_q   <= skid_vld_d;
            skid_bit_q   <= skid_bit_d;
`endif
        end
    end

endmodule

// File: tb/tb_ws2812_bit_enc.sv
// Scoreboard bench for ws2812_bit_enc: stimulus pushes expected bits, a monitor decodes the line.
module tb_ws2812_bit_enc;

    localparam int T0H  = 80;
    localparam int T1H  = 160;
    localparam int TBIT = 250;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic bit_rdy_in = 1'b0;
    logic bit_data_in = 1'b0;
    logic bit_done_out, dout_out, busy_out, overrun_out;

    int n_chk = 0;
    int n_pass = 0;
    bit exp_q[$];

    int cyc = 0, rise_cyc = 0, hi_cnt = 0, hi_len = 0;
    int done_cnt = 0, ovr_cnt = 0;
    logic prev_dout = 1'b0;
    logic [23:0] decoded = '0;

    ws2812_bit_enc #(.T0H_CNT(T0H), .T1H_CNT(T1H), .TBIT_CNT(TBIT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .bit_rdy_in(bit_rdy_in), .bit_data_in(bit_data_in),
        .bit_done_out(bit_done_out), .dout_out(dout_out), .busy_out(busy_out),
        .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: measure each high pulse and retire one expected bit per done pulse
    always @(negedge clk_in) begin
        bit e;
        cyc++;
        if (bit_done_out) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("high_time", hi_len, e ? T1H : T0H);
                check("period", cyc - rise_cyc, TBIT - 1);
                check("busy_at_done", int'(busy_out), 1);
                decoded = {decoded[22:0], (hi_len > (T0H + T1H) / 2)};
            end
        end
        if (overrun_out) ovr_cnt++;
        if (dout_out && !prev_dout) begin
            rise_cyc = cyc;
            hi_cnt   = 0;
        end
        if (dout_out) hi_cnt++;
        if (!dout_out && prev_dout) hi_len = hi_cnt;
        prev_dout = dout_out;
    end

    // Called at a negedge; returns at the negedge right after the sampling edge
    task automatic send_bit(input logic b, input bit push);
        bit_rdy_in  = 1'b1;
        bit_data_in = b;
        if (push) exp_q.push_back(b);
        @(negedge clk_in);
        bit_rdy_in = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!bit_done_out && n < 1000);
        check("done_seen", int'(bit_done_out), 1);
    endtask

    initial begin
        int n, ovr0, done0;
        logic [23:0] word;

        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_dout", int'(dout_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_done", int'(bit_done_out), 0);
        check("rst_ovr", int'(overrun_out), 0);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);

        // Single '0' then single '1' bit: latency, done position, idle afterwards
        for (int b = 0; b < 2; b++) begin
            send_bit(b[0], 1'b1);
            check("dout_before_start", int'(dout_out), 0);
            @(negedge clk_in);
            check("dout_start", int'(dout_out), 1);
            check("busy_start", int'(busy_out), 1);
            wait_done(n);
            check("done_latency", n + 1, TBIT);
            @(negedge clk_in);
            check("busy_after", int'(busy_out), 0);
            check("dout_after", int'(dout_out), 0);
            repeat (5) @(negedge clk_in);
        end

        // Handshake loop, 24 bits MSB first, next request 2 cycles after done
        word = 24'hA5C30F;
        decoded = '0;
        done0 = done_cnt;
        for (int i = 23; i >= 0; i--) begin
            send_bit(word[i], 1'b1);
            wait_done(n);
            repeat (2) @(negedge clk_in);
        end
        check("decoded_word", int'(decoded), int'(word));
        check("done_count", done_cnt - done0, 24);

        // Request in the final bit cycle chains with zero gap and no overrun
        ovr0 = ovr_cnt;
        send_bit(1'b1, 1'b1);
        repeat (TBIT - 1) @(negedge clk_in);
        send_bit(1'b0, 1'b1);
        check("done_final", int'(bit_done_out), 1);
        @(negedge clk_in);
        check("b2b_rise", int'(dout_out), 1);
        wait_done(n);
        check("b2b_period", n, TBIT - 1);
        repeat (3) @(negedge clk_in);
        check("b2b_no_ovr", ovr_cnt - ovr0, 0);

        // Mid-bit requests at cnt=100 and cnt=150
        ovr0 = ovr_cnt;
        send_bit(1'b1, 1'b1);
        repeat (100) @(negedge clk_in);
`ifdef WS2812_BIT_ENC_SKID_EN
        send_bit(1'b0, 1'b1);
`else
        send_bit(1'b0, 1'b0);
`endif
        repeat (49) @(negedge clk_in);
        send_bit(1'b1, 1'b0);
        wait_done(n);
        check("mid_done_latency", n, TBIT - 151);
        @(negedge clk_in);
`ifdef WS2812_BIT_ENC_SKID_EN
        check("skid_rise", int'(dout_out), 1);
        wait_done(n);
        check("skid_period", n, TBIT - 1);
        repeat (3) @(negedge clk_in);
        check("skid_ovr", ovr_cnt - ovr0, 1);
`else
        check("noskid_idle", int'(busy_out), 0);
        repeat (3) @(negedge clk_in);
        check("noskid_ovr", ovr_cnt - ovr0, 2);
`endif
        repeat (5) @(negedge clk_in);

        // Reset at cnt=50 of a '1' bit aborts it with no done pulse
        done0 = done_cnt;
        send_bit(1'b1, 1'b0);
`ifdef WS2812_BIT_ENC_SKID_EN
        repeat (20) @(negedge clk_in);
        send_bit(1'b0, 1'b0);
        repeat (29) @(negedge clk_in);
`else
        repeat (50) @(negedge clk_in);
`endif
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("rst_mid_dout", int'(dout_out), 0);
        check("rst_mid_busy", int'(busy_out), 0);
        check("rst_mid_done", int'(bit_done_out), 0);
        repeat (300) @(negedge clk_in);
        check("rst_no_done", done_cnt - done0, 0);
        check("rst_idle_busy", int'(busy_out), 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ws2812_bit_enc.md
# ws2812_bit_enc

WS2812 single-bit line encoder, directly downstream of the LED controller. Accepts one bit per ready pulse (bit_rdy/bit_data), drives the NRZ waveform onto the LED data pin with parameterised high/low times, and returns a one-cycle done pulse so the controller can issue the next bit. Owns only bit-level timing; frame gap and RAM sequencing stay upstream.

## Interface
- T0H_CNT, 80: high time of a '0' bit, clock cycles (0.4 us at 200 MHz)
- T1H_CNT, 160: high time of a '1' bit, clock cycles (0.8 us)
- TBIT_CNT, 250: total bit period, clock cycles (1.25 us)
- Constraint: 0 < T0H_CNT < T1H_CNT < TBIT_CNT <= 65535; counter width 16 bits.

- clk_in  input  1  clock; one clock domain
- rst_in  input  1  reset, synchronous, active-high
- bit_rdy_in  input  1  single-cycle pulse: bit_data_in valid
- bit_data_in  input  1  bit value, sampled only when bit_rdy_in=1
- bit_done_out  output  1  single-cycle pulse: current bit period finished
- dout_out  output  1  registered WS2812 data line
- busy_out  output  1  high while a bit is being shifted out
- overrun_out  output  1  single-cycle pulse: a bit_rdy_in was dropped

## Operation
- States: IDLE, SEND.
- IDLE: dout_out=0, busy_out=0. On bit_rdy_in: latch bit, cnt<=0, go SEND.
- SEND: dout_out = (cnt < TH), TH = T1H_CNT if latched bit=1 else T0H_CNT; cnt increments each cycle.
- At cnt==TBIT_CNT-1: bit_done_out=1 for that cycle. Then either start the next bit (cnt<=0, SEND) if one is pending or arriving, else IDLE.
- bit_rdy_in in the final cycle (cnt==TBIT_CNT-1) is accepted as the next bit, back-to-back, no overrun — in both configurations.
- bit_rdy_in during SEND before the final cycle: handled per Configuration.
- No done pulse is generated for a bit aborted by reset.

## Timing
- Reset (synchronous): state=IDLE, cnt=0, dout_out=0, busy_out=0, bit_done_out=0, overrun_out=0, skid cleared. Reset mid-bit forces dout_out low at the next edge.
- bit_rdy_in sampled high at edge N: dout_out=1 and busy_out=1 from edge N+1.
- dout_out high exactly TH cycles (N+1..N+TH), low for TBIT_CNT-TH cycles.
- bit_done_out high during cycle N+TBIT_CNT (last low cycle); busy_out still 1 in that cycle.
- Back-to-back bit: next rising edge of dout_out at N+TBIT_CNT+1, zero gap.
- Not back-to-back: dout_out stays 0 and busy_out drops at N+TBIT_CNT+1.
- Upstream must keep idle gap < reset-latch time (~50 us); this block does not enforce it.

## Configuration
- WS2812_BIT_ENC_SKID_EN defined: one-entry skid buffer (valid + data). bit_rdy_in during SEND before the final cycle is stored if empty and started at the end of the current bit, back-to-back; if already full, the new bit is dropped and overrun_out pulses. Stored entry is not overwritten.
- Undefined: no buffer; any bit_rdy_in during SEND before the final cycle is dropped and overrun_out pulses the same cycle.

## Test plan
- Single '0' bit: pulse bit_rdy_in with data 0 -> dout_out high 80 cycles, low 170, bit_done_out at cycle 250 after pulse, busy_out low after.
- Single '1' bit: data 1 -> high 160, low 90, bit_done_out after 250 cycles.
- Handshake loop: 24 bits 0xA5C30F, each bit_rdy_in issued 2 cycles after bit_done_out -> dout_out high times decode to 0xA5C30F MSB first, 24 done pulses.
- Final-cycle accept: bit_rdy_in coincident with bit_done_out -> next high edge next cycle, overrun_out never asserts.
- Mid-bit request at cnt=100: skid enabled -> bit starts at cycle 251 back-to-back; second mid-bit request while full -> overrun_out pulse, bit lost; skid disabled -> overrun_out pulse, line idles after 250.
- Reset at cnt=50 of a '1' bit -> dout_out=0 next cycle, no bit_done_out, busy_out=0, pending skid entry discarded.
